// File: rtl/dic_entry_ctrl_if.sv
// Character input and control/load outputs of the digital-clock entry sequencer.
// master = UART side / test driver, slave = dic_entry_ctrl.
interface dic_entry_ctrl_if;
  logic       char_vld;
  logic [7:0] char;
  logic       blink;
  logic       dic_run;
  logic       alarm_ena;
  logic       ld_time;
  logic       ld_alarm;
  logic [3:0] ld_dig;
  logic [3:0] ld_val;
  logic [3:0] dsp_en;
  logic       err;

  modport master (
    output char_vld, char, blink,
    input  dic_run, alarm_ena, ld_time, ld_alarm, ld_dig, ld_val, dsp_en, err
  );

  modport slave (
    input  char_vld, char, blink,
    output dic_run, alarm_ena, ld_time, ld_alarm, ld_dig, ld_val, dsp_en, err
  );
endinterface

// File: rtl/dic_entry_ctrl.sv
// Command/entry sequencer: run/stop, alarm arm, and 4-digit MM:SS time/alarm entry
// with per-digit range checks and an inter-character timeout. All outputs registered.
module dic_entry_ctrl #(
  parameter logic [23:0] TIMEOUT_CYC = 24'd12_000_000
) (
  input  logic              clk,
  input  logic              rst,
  dic_entry_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ENT_T, ENT_A} state_e;

  localparam logic [23:0] CNT_MAX = 24'hFF_FFFF;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] cnt_q, cnt_d;
  logic        run_q, run_d;
  logic        alm_q, alm_d;
  logic        ldt_q, ldt_d;
  logic        lda_q, lda_d;
  logic [3:0]  dig_q, dig_d;
  logic [3:0]  val_q, val_d;
  logic [3:0]  dsp_q, dsp_d;
  logic        err_q, err_d;

  logic       is_dig, is_s, is_l, is_a, is_at, is_cr, dig_ok;
  logic [3:0] dval;

  always_comb begin
    is_dig = (bus.char >= 8'h30) && (bus.char <= 8'h39);
    is_s   = (bus.char == 8'h53) || (bus.char == 8'h73);
    is_l   = (bus.char == 8'h4C) || (bus.char == 8'h6C);
    is_a   = (bus.char == 8'h41) || (bus.char == 8'h61);
    is_at  = (bus.char == 8'h40);
    is_cr  = (bus.char == 8'h0D);
    dval   = bus.char[3:0];
    // tens positions (even idx) hold 0-5, ones positions 0-9
    dig_ok = idx_q[0] ? (dval <= 4'd9) : (dval <= 4'd5);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    alm_d   = alm_q;
    dig_d   = '0;
    val_d   = '0;
    err_d   = 1'b0;
    dsp_d   = 4'hF;
    if (state_q != IDLE) dsp_d[2'd3 - idx_q] = bus.blink;

    case (state_q)
      IDLE: begin
        if (bus.char_vld) begin
          cnt_d = '0;
          if (is_s) run_d = 1'b1;
          else if (is_cr) run_d = 1'b0;
          else if (is_at) alm_d = ~alm_q;
          else if (is_l) begin
            state_d = ENT_T;
            idx_d   = '0;
            run_d   = 1'b0;
          end else if (is_a) begin
            state_d = ENT_A;
            idx_d   = '0;
          end
        end
      end
      default: begin
        if (bus.char_vld) begin
          cnt_d = '0;
          if (is_dig && dig_ok) begin
            dig_d = 4'b1000 >> idx_q;
            val_d = dval;
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) state_d = IDLE;
          end else if (is_cr) begin
            state_d = IDLE;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 24'd1;
          if (cnt_d >= TIMEOUT_CYC - 24'd1) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
    endcase

    ldt_d = (state_d == ENT_T);
    lda_d = (state_d == ENT_A);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      alm_q   <= 1'b0;
      ldt_q   <= 1'b0;
      lda_q   <= 1'b0;
      dig_q   <= '0;
      val_q   <= '0;
      dsp_q   <= 4'hF;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      alm_q   <= alm_d;
      ldt_q   <= ldt_d;
      lda_q   <= lda_d;
      dig_q   <= dig_d;
      val_q   <= val_d;
      dsp_q   <= dsp_d;
      err_q   <= err_d;
    end
  end

  assign bus.dic_run   = run_q;
  assign bus.alarm_ena = alm_q;
  assign bus.ld_time   = ldt_q;
  assign bus.ld_alarm  = lda_q;
  assign bus.ld_dig    = dig_q;
  assign bus.ld_val    = val_q;
  assign bus.dsp_en    = dsp_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_dic_entry_ctrl.sv
// Bench for dic_entry_ctrl: vector table, hand-written corner sequences, and
// randomized traffic against a behavioural model.
module tb_dic_entry_ctrl;
  localparam int TO = 16;

  localparam logic [7:0] C_S = 8'h53, C_SL = 8'h73, C_L = 8'h4C, C_LL = 8'h6C;
  localparam logic [7:0] C_A = 8'h41, C_AL = 8'h61, C_AT = 8'h40, C_CR = 8'h0D;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dic_entry_ctrl_if bus ();

  dic_entry_ctrl #(.TIMEOUT_CYC(24'd16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic       run;
    logic       alm;
    logic       ldt;
    logic       lda;
    logic [3:0] dig;
    logic [3:0] val;
    logic [3:0] dsp;
    logic       err;
  } outs_t;

  typedef struct {
    bit         vld;
    logic [7:0] ch;
    outs_t      exp;
  } vec_t;

  int tests = 0;
  int fails = 0;

  // behavioural model: mode 0 idle / 1 time entry / 2 alarm entry, pos = digit being entered
  int m_mode, m_pos, m_quiet;
  bit m_run, m_alm;

  function automatic outs_t sample();
    outs_t o;
    o.run = bus.dic_run;  o.alm = bus.alarm_ena;
    o.ldt = bus.ld_time;  o.lda = bus.ld_alarm;
    o.dig = bus.ld_dig;   o.val = bus.ld_val;
    o.dsp = bus.dsp_en;   o.err = bus.err;
    return o;
  endfunction

  function automatic outs_t mk(logic run, logic alm, logic ldt, logic lda,
                               logic [3:0] dig, logic [3:0] val, logic err);
    outs_t o;
    o.run = run; o.alm = alm; o.ldt = ldt; o.lda = lda;
    o.dig = dig; o.val = val; o.dsp = 4'hF; o.err = err;
    return o;
  endfunction

  task automatic chk(input string name, input outs_t act, input outs_t exp, input bit use_dsp);
    outs_t a, e;
    a = act; e = exp;
    if (!use_dsp) begin a.dsp = '0; e.dsp = '0; end
    if (e.dig == 4'd0) begin a.val = '0; e.val = '0; end
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got run=%b alm=%b ldt=%b lda=%b dig=%b val=%0d dsp=%b err=%b, want run=%b alm=%b ldt=%b lda=%b dig=%b val=%0d dsp=%b err=%b",
               name, a.run, a.alm, a.ldt, a.lda, a.dig, a.val, a.dsp, a.err,
               e.run, e.alm, e.ldt, e.lda, e.dig, e.val, e.dsp, e.err);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] c);
    bus.char_vld = v;
    bus.char     = c;
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    m_mode = 0; m_pos = 0; m_quiet = 0; m_run = 0; m_alm = 0;
  endfunction

  function automatic outs_t model(bit vld, logic [7:0] ch, bit bl);
    outs_t o;
    int v;
    o = '0;
    o.dsp = 4'hF;
    if (m_mode != 0) o.dsp[3 - m_pos] = bl;
    v = int'(ch) - 48;
    if (m_mode == 0) begin
      if (vld) begin
        if (ch == C_S || ch == C_SL) m_run = 1;
        else if (ch == C_CR) m_run = 0;
        else if (ch == C_AT) m_alm = !m_alm;
        else if (ch == C_L || ch == C_LL) begin m_mode = 1; m_pos = 0; m_quiet = 0; m_run = 0; end
        else if (ch == C_A || ch == C_AL) begin m_mode = 2; m_pos = 0; m_quiet = 0; end
      end
    end else if (vld) begin
      m_quiet = 0;
      if (v >= 0 && v <= 9 && v <= ((m_pos % 2 == 0) ? 5 : 9)) begin
        o.dig = 4'b1000 >> m_pos;
        o.val = v[3:0];
        m_pos++;
        if (m_pos == 4) m_mode = 0;
      end else if (ch == C_CR) begin
        m_mode = 0;
      end else begin
        o.err = 1;
      end
    end else begin
      m_quiet++;
      if (m_quiet >= TO - 1) begin m_mode = 0; o.err = 1; end
    end
    o.run = m_run; o.alm = m_alm;
    o.ldt = (m_mode == 1); o.lda = (m_mode == 2);
    return o;
  endfunction

  function automatic logic [7:0] rnd_char();
    logic [7:0] c;
    case ($urandom_range(0, 11))
      0, 1, 2, 3, 4: c = 8'h30 + 8'($urandom_range(0, 9));
      5:  c = ($urandom_range(0, 1) != 0) ? C_S : C_SL;
      6:  c = ($urandom_range(0, 1) != 0) ? C_L : C_LL;
      7:  c = ($urandom_range(0, 1) != 0) ? C_A : C_AL;
      8:  c = C_AT;
      9:  c = C_CR;
      default: c = 8'($urandom_range(0, 255));
    endcase
    return c;
  endfunction

  vec_t tbl[$];

  function automatic void add(bit vld, logic [7:0] ch, outs_t e);
    vec_t r;
    r.vld = vld; r.ch = ch; r.exp = e;
    tbl.push_back(r);
  endfunction

  initial begin
    outs_t e, got;
    int gap;
    bus.char_vld = 1'b0;
    bus.char     = 8'h00;
    bus.blink    = 1'b0;

    // T1 reset
    rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset", sample(), mk(0, 0, 0, 0, 4'b0000, 4'd0, 0), 1);
    rst = 1'b1;

    //             run alm ldt lda dig     val  err
    add(1, C_S,  mk(1, 0, 0, 0, 4'b0000, 4'd0, 0));
    add(1, C_L,  mk(0, 0, 1, 0, 4'b0000, 4'd0, 0));
    add(1, "1",  mk(0, 0, 1, 0, 4'b1000, 4'd1, 0));
    add(1, "2",  mk(0, 0, 1, 0, 4'b0100, 4'd2, 0));
    add(1, "3",  mk(0, 0, 1, 0, 4'b0010, 4'd3, 0));
    add(1, "4",  mk(0, 0, 0, 0, 4'b0001, 4'd4, 0));
    add(0, 8'h0, mk(0, 0, 0, 0, 4'b0000, 4'd0, 0));
    add(1, C_SL, mk(1, 0, 0, 0, 4'b0000, 4'd0, 0));
    add(1, C_AL, mk(1, 0, 0, 1, 4'b0000, 4'd0, 0));
    add(1, "7",  mk(1, 0, 0, 1, 4'b0000, 4'd0, 1));
    add(1, "5",  mk(1, 0, 0, 1, 4'b1000, 4'd5, 0));
    add(1, "9",  mk(1, 0, 0, 1, 4'b0100, 4'd9, 0));
    add(1, "6",  mk(1, 0, 0, 1, 4'b0000, 4'd0, 1));
    add(1, "5",  mk(1, 0, 0, 1, 4'b0010, 4'd5, 0));
    add(1, "9",  mk(1, 0, 0, 0, 4'b0001, 4'd9, 0));
    add(1, C_L,  mk(0, 0, 1, 0, 4'b0000, 4'd0, 0));
    add(1, "2",  mk(0, 0, 1, 0, 4'b1000, 4'd2, 0));
    add(1, C_S,  mk(0, 0, 1, 0, 4'b0000, 4'd0, 1));
    add(0, 8'h0, mk(0, 0, 1, 0, 4'b0000, 4'd0, 0));
    add(1, "7",  mk(0, 0, 1, 0, 4'b0100, 4'd7, 0));
    add(1, C_CR, mk(0, 0, 0, 0, 4'b0000, 4'd0, 0));
    add(1, "9",  mk(0, 0, 0, 0, 4'b0000, 4'd0, 0));
    add(1, 8'h78, mk(0, 0, 0, 0, 4'b0000, 4'd0, 0));
    add(1, C_AT, mk(0, 1, 0, 0, 4'b0000, 4'd0, 0));
    add(1, C_AT, mk(0, 0, 0, 0, 4'b0000, 4'd0, 0));
    add(1, C_AT, mk(0, 1, 0, 0, 4'b0000, 4'd0, 0));
    add(1, C_LL, mk(0, 1, 1, 0, 4'b0000, 4'd0, 0));
    add(1, C_AT, mk(0, 1, 1, 0, 4'b0000, 4'd0, 1));
    add(1, C_A,  mk(0, 1, 1, 0, 4'b0000, 4'd0, 1));
    add(1, C_CR, mk(0, 1, 0, 0, 4'b0000, 4'd0, 0));
    add(1, C_L,  mk(0, 1, 1, 0, 4'b0000, 4'd0, 0));
    add(1, "0",  mk(0, 1, 1, 0, 4'b1000, 4'd0, 0));
    add(1, C_CR, mk(0, 1, 0, 0, 4'b0000, 4'd0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].vld, tbl[i].ch);
      chk($sformatf("vec%0d", i), sample(), tbl[i].exp, 0);
    end

    // T5 timeout: err lands 15 cycles after the last char's response
    step(1, C_L);
    step(1, "3");
    chk("to_load", sample(), mk(0, 1, 1, 0, 4'b1000, 4'd3, 0), 0);
    for (int k = 1; k <= TO - 1; k++) begin
      step(0, 8'h0);
      if (k < TO - 1) chk($sformatf("to_wait%0d", k), sample(), mk(0, 1, 1, 0, 4'b0000, 4'd0, 0), 0);
      else            chk("to_fire", sample(), mk(0, 1, 0, 0, 4'b0000, 4'd0, 1), 0);
    end
    step(0, 8'h0);
    chk("to_after", sample(), mk(0, 1, 0, 0, 4'b0000, 4'd0, 0), 0);

    // reset mid-entry abandons with no load, then digits are ignored in IDLE
    step(1, C_A);
    step(1, "1");
    rst = 1'b0;
    step(1, "2");
    chk("rst_mid", sample(), mk(0, 0, 0, 0, 4'b0000, 4'd0, 0), 1);
    rst = 1'b1;
    step(1, "3");
    chk("rst_idle", sample(), mk(0, 0, 0, 0, 4'b0000, 4'd0, 0), 1);

    // dsp_en flashes the edited digit one cycle after state/idx change
    bus.blink = 1'b0;
    step(1, C_L);
    e = mk(0, 0, 1, 0, 4'b0000, 4'd0, 0);
    chk("dsp_start", sample(), e, 1);
    step(0, 8'h0);
    e.dsp = 4'b0111;
    chk("dsp_mt", sample(), e, 1);
    step(1, "4");
    e = mk(0, 0, 1, 0, 4'b1000, 4'd4, 0); e.dsp = 4'b0111;
    chk("dsp_lag", sample(), e, 1);
    bus.blink = 1'b1;
    step(0, 8'h0);
    e = mk(0, 0, 1, 0, 4'b0000, 4'd0, 0);
    chk("dsp_blink_hi", sample(), e, 1);
    bus.blink = 1'b0;
    step(0, 8'h0);
    e.dsp = 4'b1011;
    chk("dsp_mo", sample(), e, 1);
    step(1, C_CR);

    // randomized traffic against the model
    rst = 1'b0;
    step(0, 8'h0);
    rst = 1'b1;
    model_reset();
    gap = 0;
    for (int n = 0; n < 4000; n++) begin
      bit v;
      logic [7:0] c;
      bit bl;
      if (gap > 0) begin
        gap--;
        v = 0;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 40) == 0) gap = $urandom_range(5, 20);
      end
      c  = rnd_char();
      bl = ($urandom_range(0, 1) != 0);
      bus.blink = bl;
      e = model(v, c, bl);
      step(v, c);
      got = sample();
      chk($sformatf("rand%0d", n), got, e, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
